serial_add: RTL

- Bit-serial two's-complement adder for the 8-bit ALU datapath; the additive counterpart of the combinational subtractor.
- Trades area for latency: one result bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake so a sequencer can issue back-to-back operations.
- Produces sum, carry-out and signed overflow with the same meaning as the existing add/sub flag outputs.

---
 rtl/serial_add.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_add.sv
// -----------------------------------------------------------------------------
// serial_add
//   Bit-serial two's-complement adder. One full-adder cell and a carry
//   flip-flop produce one result bit per clock, LSB first. A start/busy/done
//   handshake lets a sequencer issue operations back-to-back: a start seen in
//   the DONE cycle is accepted immediately.
//
//   Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' port. With
//   sub=1 the adder computes input_1 - input_2 (B inverted, carry-in forced
//   to 1, cin ignored); cout=1 then means "no borrow".
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a new operation (sampled in IDLE or DONE only)
//   input_1      operand A, latched on the accepting edge
//   input_2      operand B, latched on the accepting edge
//   cin          carry-in, latched on the accepting edge
//   sub          (SERIAL_ADD_SUB_EN only) subtract select, latched with operands
//   busy         high while bits are being processed
//   done         one-cycle pulse, result valid
//   add_out      sum, held until the next completed operation
//   cout         carry out of the MSB, held
//   add_overflow signed overflow, held
// -----------------------------------------------------------------------------
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] add_out,
  output logic             cout,
  output logic             add_overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;      // operand A; its vacated MSBs collect the sum
  logic [WIDTH-1:0] b_q;      // operand B (inverted when subtracting)
  logic             c_q;      // running carry
  logic             a_msb;    // operand sign bits captured at latch time
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             sum_bit;
  logic             carry_bit;

`ifdef SERIAL_ADD_SUB_EN
  // a - b == a + ~b + 1
  assign b_load = sub ? ~input_2 : input_2;
  assign c_load = sub ? 1'b1     : cin;
`else
  assign b_load = input_2;
  assign c_load = cin;
`endif

  // The single full-adder cell.
  assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  // NOTE: all state updates below use non-blocking assignments so every
  // register samples the values from before the edge, like real flip-flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      add_out      <= '0;
      cout         <= 1'b0;
      add_overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= input_1;
            b_q   <= b_load;
            c_q   <= c_load;
            a_msb <= input_1[WIDTH-1];
            b_msb <= b_load[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          // A shifts right and the new sum bit enters from the MSB side, so
          // after WIDTH shifts a_q holds the complete sum without a separate
          // result shift register. add_out keeps the previous result.
          a_q <= {sum_bit, a_q[WIDTH-1:1]};
          b_q <= {1'b0, b_q[WIDTH-1:1]};
          c_q <= carry_bit;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            add_out      <= {sum_bit, a_q[WIDTH-1:1]};
            cout         <= carry_bit;
            // Same-signed operands producing a differently-signed sum.
            add_overflow <= (a_msb == b_msb) && (sum_bit != a_msb);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
